// File: rtl/usbf_txn_seq_pkg.sv
// Shared types and constants for the USB function transaction sequencer.
//  state_e  : sequencer FSM states
//  HS_*     : handshake PID codes presented on hs_pid
//  pid_t    : one-hot decoded PID strobes from the packet decoder
//  hs_code  : STALL/ACK/NAK selection from endpoint halt and readiness
package usbf_txn_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_DATA  = 3'd1,
    ST_HS       = 3'd2,
    ST_TX_DATA  = 3'd3,
    ST_WAIT_ACK = 3'd4
  } state_e;

  localparam logic [1:0] HS_ACK   = 2'b00;
  localparam logic [1:0] HS_NAK   = 2'b01;
  localparam logic [1:0] HS_STALL = 2'b10;

  localparam int unsigned NUM_EP_DEF = 4;
  localparam int unsigned TO_CYC_DEF = 40;

  typedef struct packed {
    logic tok_out;
    logic tok_in;
    logic tok_setup;
    logic tok_sof;
    logic tok_ping;
    logic hs_ack;
    logic data0;
    logic data1;
  } pid_t;

  // Halt dominates; otherwise ACK only when the endpoint can take a packet.
  function automatic logic [1:0] hs_code(input logic stall, input logic rdy);
    if (stall) return HS_STALL;
    else if (rdy) return HS_ACK;
    else return HS_NAK;
  endfunction

endpackage

// File: rtl/usbf_txn_seq_timer.sv
// Bus turnaround timer: clearable, enabled, saturating at TO_CYC.
//  clk, rst : clock, async active-low reset
//  clr      : restart count from zero
//  en       : count this cycle
//  hit_c    : count reaches TO_CYC on the coming edge (combinational)
module usbf_txn_seq_timer #(
  parameter int unsigned TO_CYC = 40,
  localparam int unsigned CW = $clog2(TO_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit_c
);

  logic [CW-1:0] cnt;

  // Saturating up-counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CW'(TO_CYC))) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Flag the edge on which the count arrives at TO_CYC so the owner can act
  // in the same cycle the limit is reached.
  assign hit_c = en && !clr && (cnt >= CW'(TO_CYC - 1));

endmodule

// File: rtl/usbf_txn_seq.sv
// USB function transaction sequencer.
// Consumes decoded tokens/PIDs and end-of-data status, decides each
// transaction outcome, drives the TX assembler through req/done handshakes
// and owns the per-endpoint DATA0/DATA1 toggles and turnaround timeout.
//  Inputs : clk, rst (async active-low), fa, token_valid/fadr/endp, crc5_err,
//           pid_cks_err, pid_* strobes, rx_data_done, crc16_err, ep_stall,
//           ep_rx_rdy, ep_tx_rdy, hs_done, tx_done
//  Outputs: send_hs/hs_pid, tx_req/tx_pid1, ep_sel, buf_commit, buf_rewind,
//           in_acked, frame_tick, to_err (all registered)
module usbf_txn_seq
  import usbf_txn_seq_pkg::*;
#(
  parameter int unsigned NUM_EP = NUM_EP_DEF,
  parameter int unsigned TO_CYC = TO_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        fa,
  input  logic              token_valid,
  input  logic [6:0]        token_fadr,
  input  logic [3:0]        token_endp,
  input  logic              crc5_err,
  input  logic              pid_cks_err,
  input  logic              pid_OUT,
  input  logic              pid_IN,
  input  logic              pid_SETUP,
  input  logic              pid_SOF,
  input  logic              pid_PING,
  input  logic              pid_ACK,
  input  logic              pid_DATA0,
  input  logic              pid_DATA1,
  input  logic              rx_data_done,
  input  logic              crc16_err,
  input  logic [NUM_EP-1:0] ep_stall,
  input  logic [NUM_EP-1:0] ep_rx_rdy,
  input  logic [NUM_EP-1:0] ep_tx_rdy,
  output logic              send_hs,
  output logic [1:0]        hs_pid,
  input  logic              hs_done,
  output logic              tx_req,
  output logic              tx_pid1,
  input  logic              tx_done,
  output logic [3:0]        ep_sel,
  output logic              buf_commit,
  output logic              buf_rewind,
  output logic              in_acked,
  output logic              frame_tick,
  output logic              to_err
);

  localparam int unsigned EW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;

  state_e            state, state_nxt;
  logic              is_setup, is_setup_nxt;
  logic [NUM_EP-1:0] tog_out, tog_out_nxt;
  logic [NUM_EP-1:0] tog_in, tog_in_nxt;
  logic              send_hs_nxt, tx_req_nxt, tx_pid1_nxt;
  logic [1:0]        hs_pid_nxt;
  logic [3:0]        ep_sel_nxt;
  logic              commit_nxt, rewind_nxt, acked_nxt, frame_nxt, to_err_nxt;
  logic              tmr_clr_c, tmr_en_c, tmr_hit_c;
  logic              good_tok_c, accept_c;
  logic [EW-1:0]     tok_idx, sel_idx;
  pid_t              pid;

  assign pid = '{tok_out: pid_OUT, tok_in: pid_IN, tok_setup: pid_SETUP,
                 tok_sof: pid_SOF, tok_ping: pid_PING, hs_ack: pid_ACK,
                 data0: pid_DATA0, data1: pid_DATA1};

  assign good_tok_c = token_valid && !crc5_err && !pid_cks_err;
  assign accept_c   = good_tok_c && (token_fadr == fa) &&
                      (32'(token_endp) < NUM_EP) && (state == ST_IDLE);
  assign tok_idx    = EW'(token_endp);
  assign sel_idx    = EW'(ep_sel);
  assign tmr_en_c   = (state == ST_RX_DATA) || (state == ST_WAIT_ACK);

  usbf_txn_seq_timer #(.TO_CYC(TO_CYC)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr_c),
    .en    (tmr_en_c),
    .hit_c (tmr_hit_c)
  );

  // Next-state and next-output decode
  always_comb begin
    state_nxt    = state;
    is_setup_nxt = is_setup;
    tog_out_nxt  = tog_out;
    tog_in_nxt   = tog_in;
    send_hs_nxt  = send_hs;
    hs_pid_nxt   = hs_pid;
    tx_req_nxt   = tx_req;
    tx_pid1_nxt  = tx_pid1;
    ep_sel_nxt   = ep_sel;
    commit_nxt   = 1'b0;
    rewind_nxt   = 1'b0;
    acked_nxt    = 1'b0;
    to_err_nxt   = 1'b0;
    tmr_clr_c    = 1'b0;
    // SOF is observed in every state and never disturbs the sequencer.
    frame_nxt    = good_tok_c && pid.tok_sof;

    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          if (pid.tok_out || pid.tok_setup) begin
            ep_sel_nxt   = token_endp;
            is_setup_nxt = pid.tok_setup;
            tmr_clr_c    = 1'b1;
            state_nxt    = ST_RX_DATA;
          end else if (pid.tok_ping) begin
            ep_sel_nxt  = token_endp;
            hs_pid_nxt  = hs_code(ep_stall[tok_idx], ep_rx_rdy[tok_idx]);
            send_hs_nxt = 1'b1;
            state_nxt   = ST_HS;
          end else if (pid.tok_in) begin
            ep_sel_nxt = token_endp;
            if (ep_stall[tok_idx] || !ep_tx_rdy[tok_idx]) begin
              hs_pid_nxt  = ep_stall[tok_idx] ? HS_STALL : HS_NAK;
              send_hs_nxt = 1'b1;
              state_nxt   = ST_HS;
            end else begin
              tx_req_nxt  = 1'b1;
              tx_pid1_nxt = tog_in[tok_idx];
              state_nxt   = ST_TX_DATA;
            end
          end
        end
      end

      ST_RX_DATA: begin
        // Data arrival beats a timeout landing on the same edge.
        if (rx_data_done) begin
          if (crc16_err || !(pid.data0 || pid.data1) ||
              (is_setup && !pid.data0)) begin
            rewind_nxt = 1'b1;
            state_nxt  = ST_IDLE;
          end else begin
            send_hs_nxt = 1'b1;
            state_nxt   = ST_HS;
            if (is_setup) begin
              // SETUP is always taken and resynchronises both directions.
              hs_pid_nxt           = HS_ACK;
              commit_nxt           = 1'b1;
              tog_out_nxt[sel_idx] = 1'b1;
              tog_in_nxt[sel_idx]  = 1'b1;
            end else if (ep_stall[sel_idx]) begin
              hs_pid_nxt = HS_STALL;
              rewind_nxt = 1'b1;
            end else if (!ep_rx_rdy[sel_idx]) begin
              hs_pid_nxt = HS_NAK;
              rewind_nxt = 1'b1;
            end else if (pid.data1 != tog_out[sel_idx]) begin
              // Retransmission of a packet already taken: ACK so the host
              // moves on, but drop the copy.
              hs_pid_nxt = HS_ACK;
              rewind_nxt = 1'b1;
            end else begin
              hs_pid_nxt           = HS_ACK;
              commit_nxt           = 1'b1;
              tog_out_nxt[sel_idx] = !tog_out[sel_idx];
            end
          end
        end else if (tmr_hit_c) begin
          to_err_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end

      ST_HS: begin
        if (hs_done) begin
          send_hs_nxt = 1'b0;
          state_nxt   = ST_IDLE;
        end
      end

      ST_TX_DATA: begin
        if (tx_done) begin
          tx_req_nxt = 1'b0;
          tmr_clr_c  = 1'b1;
          state_nxt  = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        // Host ACK carries no address; a lost ACK leaves the toggle for retry.
        if (good_tok_c && pid.hs_ack) begin
          tog_in_nxt[sel_idx] = !tog_in[sel_idx];
          acked_nxt           = 1'b1;
          state_nxt           = ST_IDLE;
        end else if (tmr_hit_c) begin
          to_err_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, toggle and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      is_setup   <= 1'b0;
      tog_out    <= '0;
      tog_in     <= '0;
      send_hs    <= 1'b0;
      hs_pid     <= 2'b00;
      tx_req     <= 1'b0;
      tx_pid1    <= 1'b0;
      ep_sel     <= 4'd0;
      buf_commit <= 1'b0;
      buf_rewind <= 1'b0;
      in_acked   <= 1'b0;
      frame_tick <= 1'b0;
      to_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      is_setup   <= is_setup_nxt;
      tog_out    <= tog_out_nxt;
      tog_in     <= tog_in_nxt;
      send_hs    <= send_hs_nxt;
      hs_pid     <= hs_pid_nxt;
      tx_req     <= tx_req_nxt;
      tx_pid1    <= tx_pid1_nxt;
      ep_sel     <= ep_sel_nxt;
      buf_commit <= commit_nxt;
      buf_rewind <= rewind_nxt;
      in_acked   <= acked_nxt;
      frame_tick <= frame_nxt;
      to_err     <= to_err_nxt;
    end
  end

endmodule

// File: tb/tb_usbf_txn_seq.sv
// Self-checking bench for usbf_txn_seq: a vector table of transactions with
// an event scoreboard, plus hand-written multi-cycle corner cases.
module tb_usbf_txn_seq;

  localparam int unsigned NUM_EP = 4;
  localparam int unsigned TO_CYC = 16;

  localparam int K_OUT = 0, K_IN = 1, K_SETUP = 2, K_PING = 3, K_SOF = 4, K_ACK = 5;
  localparam int EV_HS = 0, EV_TX = 1, EV_COMMIT = 2, EV_REWIND = 3,
                 EV_ACKED = 4, EV_TOERR = 5, EV_FRAME = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [6:0]        fa;
  logic              token_valid;
  logic [6:0]        token_fadr;
  logic [3:0]        token_endp;
  logic              crc5_err, pid_cks_err;
  logic              pid_OUT, pid_IN, pid_SETUP, pid_SOF, pid_PING, pid_ACK, pid_DATA0, pid_DATA1;
  logic              rx_data_done, crc16_err;
  logic [NUM_EP-1:0] ep_stall, ep_rx_rdy, ep_tx_rdy;
  logic              send_hs, tx_req, tx_pid1, hs_done, tx_done;
  logic [1:0]        hs_pid;
  logic [3:0]        ep_sel;
  logic              buf_commit, buf_rewind, in_acked, frame_tick, to_err;

  usbf_txn_seq #(.NUM_EP(NUM_EP), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .fa(fa),
    .token_valid(token_valid), .token_fadr(token_fadr), .token_endp(token_endp),
    .crc5_err(crc5_err), .pid_cks_err(pid_cks_err),
    .pid_OUT(pid_OUT), .pid_IN(pid_IN), .pid_SETUP(pid_SETUP), .pid_SOF(pid_SOF),
    .pid_PING(pid_PING), .pid_ACK(pid_ACK), .pid_DATA0(pid_DATA0), .pid_DATA1(pid_DATA1),
    .rx_data_done(rx_data_done), .crc16_err(crc16_err),
    .ep_stall(ep_stall), .ep_rx_rdy(ep_rx_rdy), .ep_tx_rdy(ep_tx_rdy),
    .send_hs(send_hs), .hs_pid(hs_pid), .hs_done(hs_done),
    .tx_req(tx_req), .tx_pid1(tx_pid1), .tx_done(tx_done),
    .ep_sel(ep_sel), .buf_commit(buf_commit), .buf_rewind(buf_rewind),
    .in_acked(in_acked), .frame_tick(frame_tick), .to_err(to_err)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int data; } ev_t;
  ev_t exp_q[$];

  typedef struct {
    int         kind;
    logic [6:0] fadr;
    logic [3:0] ep;
    logic       d1, crc, stall, rxr, txr;
    int         exp_hs;   // -1: no handshake
    int         exp_tx;   // -1: no data packet
    int         exp_buf;  // 0 none, 1 commit, 2 rewind
    bit         host_ack;
    bit         ign;
  } vec_t;

  vec_t vecs[20];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   hs_q = 1'b0, tx_q = 1'b0;

  function automatic string ev_name(input int k);
    case (k)
      EV_HS:     return "hs";
      EV_TX:     return "tx";
      EV_COMMIT: return "commit";
      EV_REWIND: return "rewind";
      EV_ACKED:  return "in_acked";
      EV_TOERR:  return "to_err";
      default:   return "frame";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  task automatic push(input int k, input int d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every DUT event must match the oldest expectation.
  task automatic got(input int k, input int d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL sb_unexpected: got %s/%0d, want no event", ev_name(k), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == k && e.data == d) n_pass++;
      else $display("FAIL sb_event: got %s/%0d, want %s/%0d", ev_name(k), d, ev_name(e.kind), e.data);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (send_hs && !hs_q) got(EV_HS, int'(hs_pid));
    if (tx_req && !tx_q)  got(EV_TX, int'(tx_pid1));
    if (buf_commit)       got(EV_COMMIT, 0);
    if (buf_rewind)       got(EV_REWIND, 0);
    if (in_acked)         got(EV_ACKED, 0);
    if (to_err)           got(EV_TOERR, 0);
    if (frame_tick)       got(EV_FRAME, 0);
    hs_q = send_hs;
    tx_q = tx_req;
  endtask

  task automatic send_token(input int kind, input logic [6:0] fadr, input logic [3:0] ep);
    token_valid = 1'b1; token_fadr = fadr; token_endp = ep;
    pid_OUT = (kind == K_OUT); pid_IN = (kind == K_IN); pid_SETUP = (kind == K_SETUP);
    pid_PING = (kind == K_PING); pid_SOF = (kind == K_SOF); pid_ACK = (kind == K_ACK);
    step();
    token_valid = 1'b0;
    {pid_OUT, pid_IN, pid_SETUP, pid_PING, pid_SOF, pid_ACK} = '0;
  endtask

  task automatic send_data(input logic d1, input logic crc);
    rx_data_done = 1'b1; pid_DATA0 = !d1; pid_DATA1 = d1; crc16_err = crc;
    step();
    rx_data_done = 1'b0; pid_DATA0 = 1'b0; pid_DATA1 = 1'b0; crc16_err = 1'b0;
  endtask

  task automatic wait_sig(input int which, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if ((which == 0 && send_hs) || (which == 1 && tx_req)) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wait_%s: got timeout, want signal high", (which == 0) ? "send_hs" : "tx_req");
    end
  endtask

  task automatic finish_hs(input int exp_pid);
    bit ok;
    wait_sig(0, ok);
    if (ok) begin
      step();
      check("send_hs_hold", int'(send_hs), 1);
      check("hs_pid_hold", int'(hs_pid), exp_pid);
      hs_done = 1'b1;
      step();
      hs_done = 1'b0;
      check("send_hs_drop", int'(send_hs), 0);
    end
  endtask

  initial begin
    bit ok, early;
    vec_t v;

    vecs[0]  = '{K_OUT,   7'h05, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  0, -1, 1, 1'b0, 1'b0};
    vecs[1]  = '{K_OUT,   7'h05, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  0, -1, 2, 1'b0, 1'b0};
    vecs[2]  = '{K_OUT,   7'h05, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  0, -1, 1, 1'b0, 1'b0};
    vecs[3]  = '{K_IN,    7'h05, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1,  0, 0, 1'b1, 1'b0};
    vecs[4]  = '{K_IN,    7'h05, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1,  1, 0, 1'b0, 1'b0};
    vecs[5]  = '{K_IN,    7'h05, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1,  1, 0, 1'b1, 1'b0};
    vecs[6]  = '{K_IN,    7'h05, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,  2, -1, 0, 1'b0, 1'b0};
    vecs[7]  = '{K_OUT,   7'h05, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1, 2, 1'b0, 1'b0};
    vecs[8]  = '{K_IN,    7'h05, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1, -1, 0, 1'b0, 1'b0};
    vecs[9]  = '{K_PING,  7'h05, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  0, -1, 0, 1'b0, 1'b0};
    vecs[10] = '{K_PING,  7'h05, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1, -1, 0, 1'b0, 1'b0};
    vecs[11] = '{K_PING,  7'h05, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  2, -1, 0, 1'b0, 1'b0};
    vecs[12] = '{K_OUT,   7'h05, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1, -1, 2, 1'b0, 1'b0};
    vecs[13] = '{K_OUT,   7'h05, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  2, -1, 2, 1'b0, 1'b0};
    vecs[14] = '{K_SETUP, 7'h05, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,  0, -1, 1, 1'b0, 1'b0};
    vecs[15] = '{K_IN,    7'h05, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1,  1, 0, 1'b1, 1'b0};
    vecs[16] = '{K_OUT,   7'h05, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,  0, -1, 1, 1'b0, 1'b0};
    vecs[17] = '{K_OUT,   7'h06, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1, 0, 1'b0, 1'b1};
    vecs[18] = '{K_IN,    7'h05, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 0, 1'b0, 1'b1};
    vecs[19] = '{K_OUT,   7'h05, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  0, -1, 1, 1'b0, 1'b0};

    rst = 1'b0; fa = 7'h05;
    token_valid = 1'b0; token_fadr = '0; token_endp = '0; crc5_err = 1'b0; pid_cks_err = 1'b0;
    {pid_OUT, pid_IN, pid_SETUP, pid_SOF, pid_PING, pid_ACK, pid_DATA0, pid_DATA1} = '0;
    rx_data_done = 1'b0; crc16_err = 1'b0; hs_done = 1'b0; tx_done = 1'b0;
    ep_stall = '0; ep_rx_rdy = '0; ep_tx_rdy = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({send_hs, hs_pid, tx_req, tx_pid1, ep_sel, buf_commit,
                                 buf_rewind, in_acked, frame_tick, to_err}), 0);
    rst = 1'b1;
    step();

    // Table of transactions
    for (int i = 0; i < 20; i++) begin
      v = vecs[i];
      ep_stall = '0; ep_rx_rdy = '0; ep_tx_rdy = '0;
      if (v.ign) begin
        ep_rx_rdy = '1; ep_tx_rdy = '1;
      end else begin
        ep_stall[v.ep] = v.stall; ep_rx_rdy[v.ep] = v.rxr; ep_tx_rdy[v.ep] = v.txr;
      end
      if (v.exp_hs >= 0) push(EV_HS, v.exp_hs);
      if (v.exp_tx >= 0) push(EV_TX, v.exp_tx);
      if (v.exp_buf == 1) push(EV_COMMIT, 0);
      if (v.exp_buf == 2) push(EV_REWIND, 0);
      send_token(v.kind, v.fadr, v.ep);
      if (v.kind == K_OUT || v.kind == K_SETUP) begin
        step(); step();
        send_data(v.d1, v.crc);
      end
      if (v.ign) begin
        step(); step();
        check($sformatf("ignored_%0d", i), int'({send_hs, tx_req, buf_commit, buf_rewind}), 0);
      end else if (v.exp_hs >= 0) begin
        check($sformatf("ep_sel_%0d", i), int'(ep_sel), int'(v.ep));
        finish_hs(v.exp_hs);
      end else if (v.exp_tx >= 0) begin
        wait_sig(1, ok);
        if (ok) begin
          check($sformatf("ep_sel_%0d", i), int'(ep_sel), int'(v.ep));
          step(); step();
          check("tx_req_hold", int'(tx_req), 1);
          tx_done = 1'b1;
          step();
          tx_done = 1'b0;
          check("tx_req_drop", int'(tx_req), 0);
          if (v.host_ack) begin
            step(); step();
            push(EV_ACKED, 0);
            send_token(K_ACK, 7'h00, 4'd0);
          end else begin
            push(EV_TOERR, 0);
            early = 1'b0;
            for (int k = 1; k <= int'(TO_CYC); k++) begin
              step();
              if (k < int'(TO_CYC) && to_err) early = 1'b1;
              if (k == int'(TO_CYC)) check("to_err_at_limit", int'(to_err), 1);
            end
            check("to_err_early", int'(early), 0);
          end
        end
      end else begin
        step(); step();
        check($sformatf("no_hs_%0d", i), int'(send_hs), 0);
      end
      step();
    end

    // SOF and tokens while a handshake is pending
    ep_stall = '0; ep_rx_rdy = 4'b0001; ep_tx_rdy = 4'b0100;
    push(EV_HS, 0);
    send_token(K_PING, 7'h05, 4'd0);
    wait_sig(0, ok);
    push(EV_FRAME, 0);
    send_token(K_SOF, 7'h33, 4'hA);
    crc5_err = 1'b1;
    send_token(K_SOF, 7'h33, 4'hA);
    crc5_err = 1'b0;
    send_token(K_IN, 7'h05, 4'd2);
    check("hs_hold_during_tokens", int'(send_hs), 1);
    hs_done = 1'b1;
    send_token(K_IN, 7'h05, 4'd2);
    hs_done = 1'b0;
    step(); step(); step();
    check("in_with_hs_done_ignored", int'({send_hs, tx_req}), 0);

    // Data arriving on the very edge the timer would expire: data wins
    ep_rx_rdy = '1;
    push(EV_HS, 0);
    push(EV_COMMIT, 0);
    send_token(K_OUT, 7'h05, 4'd0);
    repeat (TO_CYC - 1) step();
    send_data(1'b0, 1'b0);
    finish_hs(0);
    step();

    // No data at all: receive timeout
    push(EV_TOERR, 0);
    send_token(K_OUT, 7'h05, 4'd0);
    repeat (TO_CYC + 2) step();

    // Reset while a data packet is requested
    ep_tx_rdy = 4'b0100;
    push(EV_TX, 0);
    send_token(K_IN, 7'h05, 4'd2);
    wait_sig(1, ok);
    rst = 1'b0;
    #1;
    check("rst_drops_tx_req", int'(tx_req), 0);
    step(); step();
    rst = 1'b1;
    step();
    // Toggle for ep1 was 1 before reset; DATA0 must now be accepted as new.
    push(EV_HS, 0);
    push(EV_COMMIT, 0);
    send_token(K_OUT, 7'h05, 4'd1);
    step(); step();
    send_data(1'b0, 1'b0);
    finish_hs(0);
    step(); step();

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
